// File: rtl/voice_pkg.sv
// Shared definitions for the synth voice: waveform codes, ADSR state
// encoding and the noise LFSR polynomial with its step function.
package voice_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_t;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // 16-bit Galois LFSR, shift right, taps 0xB400
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/adsr_env.sv
// ADSR envelope generator: state machine plus level register.
// Ports: clk, rst (sync, active high), gate, attack/decay/release rates,
// sustain level byte; outputs level (ENV_BITS) and state.
module adsr_env
    import voice_pkg::*;
#(
    parameter int ENV_BITS   = 16,
    parameter int RATE_SHIFT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gate,
    input  logic [7:0]          attack_rate,
    input  logic [7:0]          decay_rate,
    input  logic [7:0]          sustain_lvl,
    input  logic [7:0]          release_rate,
    output logic [ENV_BITS-1:0] level,
    output env_state_t          state
);

    localparam int W = ENV_BITS + 1;
    localparam logic [W-1:0] FULL = {1'b0, {ENV_BITS{1'b1}}};

    env_state_t          state_next;
    logic [ENV_BITS-1:0] level_next;
    logic                gate_d;
    logic                rise;
    logic                fall;
    logic [W-1:0]        lvl;
    logic [W-1:0]        tgt;
    logic [W-1:0]        a_step;
    logic [W-1:0]        d_step;
    logic [W-1:0]        r_step;
    logic [31:0]         sus_rep;

    assign rise = gate & ~gate_d;
    assign fall = ~gate & gate_d;
    assign lvl  = {1'b0, level};

    // Sustain byte replicated across the level width ({s,s} at 16 bits)
    assign sus_rep = {4{sustain_lvl}};
    assign tgt     = {1'b0, ENV_BITS'(sus_rep >> (32 - ENV_BITS))};

    assign a_step = W'(attack_rate) << RATE_SHIFT;
    assign d_step = W'(decay_rate) << RATE_SHIFT;
    assign r_step = W'(release_rate) << RATE_SHIFT;

    always_comb begin
        state_next = state;
        level_next = level;
        // Gate edges win over stepping and leave the level untouched
        if (rise) begin
            state_next = ENV_ATTACK;
        end else if (fall && (state == ENV_ATTACK || state == ENV_DECAY ||
                              state == ENV_SUSTAIN)) begin
            state_next = ENV_RELEASE;
        end else begin
            unique case (state)
                ENV_IDLE: begin
                end
                ENV_ATTACK: begin
                    if (attack_rate == 8'd0 || (lvl + a_step) >= FULL) begin
                        level_next = FULL[ENV_BITS-1:0];
                        state_next = ENV_DECAY;
                    end else begin
                        level_next = ENV_BITS'(lvl + a_step);
                    end
                end
                ENV_DECAY: begin
                    // level - step <= target, rearranged to avoid underflow
                    if (decay_rate == 8'd0 || lvl <= (tgt + d_step)) begin
                        level_next = tgt[ENV_BITS-1:0];
                        state_next = ENV_SUSTAIN;
                    end else begin
                        level_next = ENV_BITS'(lvl - d_step);
                    end
                end
                ENV_SUSTAIN: begin
                    level_next = tgt[ENV_BITS-1:0];
                end
                ENV_RELEASE: begin
                    if (release_rate == 8'd0 || lvl <= r_step) begin
                        level_next = '0;
                        state_next = ENV_IDLE;
                    end else begin
                        level_next = ENV_BITS'(lvl - r_step);
                    end
                end
                default: begin
                    level_next = '0;
                    state_next = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ENV_IDLE;
            level  <= '0;
            gate_d <= 1'b0;
        end else begin
            state  <= state_next;
            level  <= level_next;
            gate_d <= gate;
        end
    end

endmodule

// File: rtl/voice_adsr.sv
// Synth voice: phase-accumulator oscillator (saw/pulse/tri/noise),
// ADSR envelope and registered VCA. One sample per sample_clock edge.
// Ports: sample_clock, rst (sync, active high), pitch_increment,
// waveform, pulse_width, env_attack/decay/sustain/release, gate;
// outputs out (signed sample), env_state, active.
module voice_adsr
    import voice_pkg::*;
#(
    parameter int          BITDEPTH   = 14,
    parameter int          ACC_BITS   = 20,
    parameter int          ENV_BITS   = 16,
    parameter int          RATE_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                       sample_clock,
    input  logic                       rst,
    input  logic [15:0]                pitch_increment,
    input  logic [1:0]                 waveform,
    input  logic [7:0]                 pulse_width,
    input  logic [7:0]                 env_attack,
    input  logic [7:0]                 env_decay,
    input  logic [7:0]                 env_sustain,
    input  logic [7:0]                 env_release,
    input  logic                       gate,
    output logic signed [BITDEPTH-1:0] out,
    output logic [2:0]                 env_state,
    output logic                       active
);

    localparam logic [BITDEPTH-1:0] POS_MAX = {1'b0, {(BITDEPTH-1){1'b1}}};
    localparam logic [BITDEPTH-1:0] NEG_MAX = {1'b1, {(BITDEPTH-1){1'b0}}};

    logic [ACC_BITS-1:0]               phase;
    logic [ACC_BITS:0]                 phase_sum;
    logic [15:0]                       lfsr;
    logic [BITDEPTH-1:0]               p;
    logic [BITDEPTH-2:0]               fold;
    logic signed [BITDEPTH-1:0]        osc;
    logic signed [BITDEPTH+ENV_BITS:0] prod;
    logic [ENV_BITS-1:0]               level;
    env_state_t                        st;

    adsr_env #(
        .ENV_BITS   (ENV_BITS),
        .RATE_SHIFT (RATE_SHIFT)
    ) u_env (
        .clk          (sample_clock),
        .rst          (rst),
        .gate         (gate),
        .attack_rate  (env_attack),
        .decay_rate   (env_decay),
        .sustain_lvl  (env_sustain),
        .release_rate (env_release),
        .level        (level),
        .state        (st)
    );

    assign env_state = st;
    assign active    = (st != ENV_IDLE);

    assign phase_sum = {1'b0, phase} + (ACC_BITS + 1)'(pitch_increment);
    assign p         = BITDEPTH'(phase >> (ACC_BITS - BITDEPTH));

    // Triangle: mirror the lower bits in the second half, then double
    assign fold = p[BITDEPTH-1] ? ~p[BITDEPTH-2:0] : p[BITDEPTH-2:0];

    always_comb begin
        osc = '0;
        unique case (wave_t'(waveform))
            WAVE_SAW:   osc = {~p[BITDEPTH-1], p[BITDEPTH-2:0]};
            WAVE_PULSE: osc = (phase[ACC_BITS-1 -: 8] < pulse_width)
                              ? POS_MAX : NEG_MAX;
            WAVE_TRI:   osc = {~fold[BITDEPTH-2], fold[BITDEPTH-3:0], 1'b0};
            WAVE_NOISE: osc = BITDEPTH'(lfsr >> (16 - BITDEPTH));
            default:    osc = '0;
        endcase
    end

    assign prod = osc * $signed({1'b0, level});

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            phase <= '0;
            lfsr  <= LFSR_SEED;
            out   <= '0;
        end else begin
            phase <= phase_sum[ACC_BITS-1:0];
            // Noise advances once per oscillator period
            if (phase_sum[ACC_BITS]) begin
                lfsr <= lfsr_step(lfsr);
            end
            out <= BITDEPTH'(prod >>> ENV_BITS);
        end
    end

endmodule
